// File: rtl/body_fetch_master_if.sv
// body_fetch_master_if: Avalon-MM read bus between the body fetch master and the regfile slave
interface body_fetch_master_if;
    logic        avl_cs;
    logic        avl_read;
    logic        avl_write;
    logic [3:0]  avl_byte_en;
    logic [7:0]  avl_addr;
    logic [31:0] avl_writedata;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    modport master (
        output avl_cs, avl_read, avl_write, avl_byte_en, avl_addr, avl_writedata,
        input  avl_waitrequest, avl_readdata
    );
    modport slave (
        input  avl_cs, avl_read, avl_write, avl_byte_en, avl_addr, avl_writedata,
        output avl_waitrequest, avl_readdata
    );
endinterface

// File: rtl/body_fetch_master.sv
// body_fetch_master: per-frame Avalon-MM fetch of body radius/position words into double-buffered outputs
module body_fetch_master #(
    parameter int NUM_BODIES     = 4,
    parameter int BASE_RAD       = 14,
    parameter int BASE_X         = 24,
    parameter int BASE_Y         = 34,
    parameter int BASE_Z         = 44,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start_i,
    body_fetch_master_if.master       avl,
    output logic [NUM_BODIES*10-1:0]  body_rad_o,
    output logic [NUM_BODIES*10-1:0]  body_x_o,
    output logic [NUM_BODIES*10-1:0]  body_y_o,
    output logic [NUM_BODIES*10-1:0]  body_z_o,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      error_o,
    output logic [7:0]                overrun_cnt_o
);
    localparam int W = NUM_BODIES * 10;
    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;
    state_t              state_q;
    logic                read_q;
    logic                done_q;
    logic                err_q;
    logic [7:0]          addr_q;
    logic [7:0]          ovr_q;
    logic [3:0]          body_q;
    logic [1:0]          fld_q;
    logic [15:0]         stall_q;
    logic [3:0][W-1:0]   stg_q;
    logic [3:0][W-1:0]   out_q;
    logic                accept;
    logic                last;
    logic [3:0]          body_d;
    logic [1:0]          fld_d;
    logic [7:0]          addr_d;
    logic                unused_hi;
    function automatic logic [7:0] base(input logic [1:0] f);
        return f == 2'd0 ? 8'(BASE_RAD) : f == 2'd1 ? 8'(BASE_X) : f == 2'd2 ? 8'(BASE_Y) : 8'(BASE_Z);
    endfunction
    // Next read position in body-major, field-minor order
    always_comb begin
        accept = read_q && !avl.avl_waitrequest;
        last   = body_q == 4'(NUM_BODIES - 1) && fld_q == 2'd3;
        fld_d  = fld_q + 2'd1;
        body_d = fld_q == 2'd3 ? body_q + 4'd1 : body_q;
        addr_d = base(fld_d) + 8'(body_d);
    end
    // Fetch FSM: issue reads, stage fields, commit the whole frame at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            ovr_q   <= '0;
            body_q  <= '0;
            fld_q   <= '0;
            stall_q <= '0;
            stg_q   <= '0;
            out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (frame_start_i && state_q != IDLE && ovr_q != 8'hFF)
                ovr_q <= ovr_q + 8'd1;
            case (state_q)
                IDLE: if (frame_start_i) begin
                    state_q <= ISSUE;
                    read_q  <= 1'b1;
                    addr_q  <= base(2'd0);
                    body_q  <= '0;
                    fld_q   <= '0;
                    stall_q <= '0;
                end
                ISSUE: if (accept) begin
                    stg_q[fld_q][10*body_q +: 10] <= avl.avl_readdata[9:0];
                    stall_q <= '0;
                    if (last) begin
                        state_q <= COMMIT;
                        read_q  <= 1'b0;
                    end else begin
                        fld_q  <= fld_d;
                        body_q <= body_d;
                        addr_q <= addr_d;
                    end
                end else if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    err_q   <= 1'b1;
                    stall_q <= '0;
                end else begin
                    stall_q <= stall_q + 16'd1;
                end
                COMMIT: begin
                    out_q   <= stg_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign unused_hi         = ^avl.avl_readdata[31:10];
    assign avl.avl_cs        = read_q;
    assign avl.avl_read      = read_q;
    assign avl.avl_write     = 1'b0;
    assign avl.avl_byte_en   = 4'b1111;
    assign avl.avl_addr      = addr_q;
    assign avl.avl_writedata = '0;
    assign body_rad_o        = out_q[0];
    assign body_x_o          = out_q[1];
    assign body_y_o          = out_q[2];
    assign body_z_o          = out_q[3];
    assign busy_o            = state_q != IDLE;
    assign frame_done_o      = done_q;
    assign error_o           = err_q;
    assign overrun_cnt_o     = ovr_q;
endmodule

// File: tb/tb_body_fetch_master.sv
// tb_body_fetch_master: directed and randomized checks of body_fetch_master against a per-cycle reference model
module tb_body_fetch_master;
    localparam int N = 4;
    localparam int T = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fs = 1'b0;
    logic wr = 1'b0;
    logic [31:0] salt = '0;
    logic chk_en = 1'b0;
    logic [N*10-1:0] rad, x, y, z;
    logic busy, done, err;
    logic [7:0] ovr;
    int checks = 0;
    int failures = 0;
    body_fetch_master_if bus();
    body_fetch_master #(.NUM_BODIES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .frame_start_i(fs), .avl(bus),
        .body_rad_o(rad), .body_x_o(x), .body_y_o(y), .body_z_o(z),
        .busy_o(busy), .frame_done_o(done), .error_o(err), .overrun_cnt_o(ovr)
    );
    // Slave: zero-latency data derived from the address and a per-pass salt
    function automatic logic [31:0] dfn(input logic [7:0] a, input logic [31:0] s);
        return s == 0 ? 32'(a) * 32'd3 : s == 1 ? 32'hFFFF_FC05 : (32'(a) * 32'h9E3779B1) ^ s;
    endfunction
    assign bus.avl_waitrequest = wr;
    assign bus.avl_readdata = dfn(bus.avl_addr, salt);
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // Reference model: a pass is a list of 4N reads, read k at base[k%4] + k/4
    int base_a[4] = '{14, 24, 34, 44};
    int mb[4][N];
    int ms[4][N];
    bit m_act, m_com, m_done, m_err;
    int m_k, m_stall, m_ovr;
    function automatic int m_addr();
        return base_a[m_k % 4] + m_k / 4;
    endfunction
    // Compare DUT against model for this cycle, then advance model with this cycle's inputs
    always @(negedge clk) begin
        if (chk_en) begin
            chk("read", bus.avl_read, m_act);
            chk("cs", bus.avl_cs, m_act);
            if (m_act) chk("addr", bus.avl_addr, m_addr());
            chk("busy", busy, m_act || m_com);
            chk("done", done, m_done);
            chk("error", err, m_err);
            chk("overrun", ovr, m_ovr);
            chk("ties", {bus.avl_write, bus.avl_byte_en, bus.avl_writedata}, {1'b0, 4'hF, 32'h0});
            for (int b = 0; b < N; b++) begin
                chk("rad", rad[10*b +: 10], mb[0][b]);
                chk("x", x[10*b +: 10], mb[1][b]);
                chk("y", y[10*b +: 10], mb[2][b]);
                chk("z", z[10*b +: 10], mb[3][b]);
            end
        end
        if (rst) begin
            m_act = 0; m_com = 0; m_done = 0; m_err = 0;
            m_k = 0; m_stall = 0; m_ovr = 0;
            for (int f = 0; f < 4; f++)
                for (int b = 0; b < N; b++) begin
                    mb[f][b] = 0;
                    ms[f][b] = 0;
                end
        end else begin
            if (fs && (m_act || m_com) && m_ovr < 255) m_ovr++;
            m_done = 0;
            if (m_com) begin
                mb = ms;
                m_com = 0;
                m_done = 1;
            end else if (m_act) begin
                if (!wr) begin
                    ms[m_k % 4][m_k / 4] = int'(dfn(8'(m_addr()), salt) & 32'h3FF);
                    m_stall = 0;
                    if (m_k == 4 * N - 1) begin
                        m_act = 0;
                        m_com = 1;
                    end else m_k++;
                end else begin
                    m_stall++;
                    if (m_stall == T) begin
                        m_act = 0;
                        m_err = 1;
                        m_stall = 0;
                    end
                end
            end else if (fs) begin
                m_act = 1;
                m_k = 0;
                m_stall = 0;
            end
        end
    end
    task automatic tic();
        @(posedge clk);
        #2;
    endtask
    task automatic wait_done(input int start, output int c);
        c = start;
        while (!done && c < start + 60) begin
            tic();
            c++;
        end
    endtask
    int lit[16] = '{14, 24, 34, 44, 15, 25, 35, 45, 16, 26, 36, 46, 17, 27, 37, 47};
    int c, dcount, pct;
    int pcts[4] = '{0, 20, 50, 90};
    logic [N*10-1:0] saved;
    initial begin
        repeat (2) tic();
        rst = 0;
        chk_en = 1;
        chk("rst_read", bus.avl_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", bus.avl_addr, 0);
        chk("rst_x", x, 0);
        // Zero-wait pass, slave returns addr*3
        fs = 1; tic(); fs = 0;
        for (int i = 1; i <= 16; i++) begin
            chk("seq_addr", bus.avl_addr, lit[i-1]);
            chk("seq_read", bus.avl_read, 1);
            tic();
        end
        chk("commit_done", done, 0);
        chk("commit_busy", busy, 1);
        tic();
        chk("done_c18", done, 1);
        chk("x_b1", x[19:10], 75);
        chk("rad_b0", rad[9:0], 42);
        chk("z_b3", z[39:30], 141);
        tic();
        chk("done_pulse", done, 0);
        // Upper read-data bits discarded
        salt = 1; fs = 1; tic(); fs = 0;
        wait_done(1, c);
        chk("hi_done_cycle", c, 18);
        chk("hi_rad", rad[9:0], 10'h005);
        chk("hi_z", z[39:30], 10'h005);
        // Three-cycle wait on the second read
        salt = 0; fs = 1; tic(); fs = 0;
        tic();
        for (int i = 2; i <= 5; i++) begin
            wr = i <= 4;
            chk("hold_addr", bus.avl_addr, 24);
            tic();
        end
        wr = 0;
        wait_done(6, c);
        chk("wait_done_cycle", c, 21);
        chk("wait_x", x[19:10], 75);
        // Stuck wait-request times out
        saved = x;
        salt = 7; fs = 1; tic(); fs = 0; wr = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("to_read", bus.avl_read, 1);
            tic();
        end
        chk("to_read_drop", bus.avl_read, 0);
        chk("to_error", err, 1);
        chk("to_busy", busy, 0);
        chk("to_x_kept", x, saved);
        wr = 0;
        dcount = 0;
        repeat (5) begin
            dcount += int'(done);
            tic();
        end
        chk("to_no_done", dcount, 0);
        // Overrun pulses during a pass
        rst = 1; tic(); rst = 0;
        salt = 0; fs = 1; tic(); fs = 0;
        dcount = 0;
        for (int i = 1; i <= 30; i++) begin
            fs = i == 3 || i == 6 || i == 9;
            dcount += int'(done);
            tic();
        end
        fs = 0;
        chk("ovr3", ovr, 3);
        chk("single_done", dcount, 1);
        chk("err_cleared", err, 0);
        fs = 1;
        repeat (400) tic();
        fs = 0;
        repeat (20) tic();
        chk("ovr_sat", ovr, 255);
        // Reset mid-pass
        salt = 5; fs = 1; tic(); fs = 0;
        repeat (6) tic();
        rst = 1; tic();
        rst = 0;
        chk("mr_read", bus.avl_read, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ovr", ovr, 0);
        chk("mr_x", x, 0);
        fs = 1; tic(); fs = 0;
        wait_done(1, c);
        chk("mr_next_pass", c, 18);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = pcts[$urandom_range(0, 3)];
            wr = ($urandom % 100) < pct;
            fs = ($urandom % 100) < 6;
            rst = ($urandom % 1000) == 0;
            if (done) salt = $urandom;
            tic();
        end
        rst = 0; fs = 0; wr = 0;
        repeat (3) tic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
